// File: rtl/calc_pkg.sv
// Shared types for the calculator command path: opcodes, issuer FSM states
// and the packed command word stored in the FIFO.
package calc_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_OR  = 2'b10,
      OP_EQ  = 2'b11
   } calc_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_CAPTURE,
      ST_WAIT
   } issuer_state_e;

   typedef struct packed {
      calc_op_e   op;
      logic [7:0] operand;
   } calc_cmd_t;

endpackage

// File: rtl/calc_cmd_fifo.sv
// Command FIFO for the issuer: DEPTH entries (power of two), wrapping pointers,
// occupancy count and a synchronous flush that drops any same-edge push.
module calc_cmd_fifo
   import calc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  calc_cmd_t              wr_data,
   output calc_cmd_t              rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   calc_cmd_t      mem [DEPTH];
   logic [PW-1:0]  wr_ptr_reg;
   logic [PW-1:0]  rd_ptr_reg;
   logic [CW-1:0]  count_reg;
   logic           push_ok;
   logic           pop_ok;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign pop_ok  = pop && !empty;
   // A pop frees the head slot first, so a full FIFO can still take a push.
   assign push_ok = push && !flush && (!full || pop_ok);

   // Storage is not reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
      end
   end

   // The issuer registers the head on the pop edge.
   assign rd_data = mem[rd_ptr_reg];
   assign count   = count_reg;

endmodule

// File: rtl/calc_cmd_issuer.sv
// Command issuer: queues host calculator commands and replays them one at a
// time, capturing each result and enforcing an idle gap between operations.
module calc_cmd_issuer
   import calc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int GAP   = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [7:0]             cmd_operand,
   input  logic                   flush,
   output logic                   calc_stb,
   output logic [1:0]             calc_op,
   output logic [7:0]             calc_operand,
   input  logic [7:0]             calc_result,
   output logic                   rsp_valid,
   output logic [7:0]             rsp_data,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] count
);
   localparam logic [3:0] WAIT_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   issuer_state_e state_reg, state_next;
   logic [3:0]    wait_cnt_reg, wait_cnt_next;
   logic          calc_stb_reg, calc_stb_next;
   calc_op_e      calc_op_reg, calc_op_next;
   logic [7:0]    calc_operand_reg, calc_operand_next;
   logic          rsp_valid_reg, rsp_valid_next;
   logic [7:0]    rsp_data_reg, rsp_data_next;

   calc_cmd_t     head_cmd;
   calc_cmd_t     wr_cmd;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop_now;
   logic          push_now;

   assign pop_now   = (state_reg == ST_IDLE) && !fifo_empty;
   assign cmd_ready = !fifo_full || pop_now;
   assign push_now  = cmd_valid && cmd_ready;
   assign wr_cmd    = '{op: calc_op_e'(cmd_op), operand: cmd_operand};

   calc_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_now),
      .pop     (pop_now),
      .flush   (flush),
      .wr_data (wr_cmd),
      .rd_data (head_cmd),
      .count   (count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      state_next        = state_reg;
      wait_cnt_next     = wait_cnt_reg;
      calc_stb_next     = 1'b0;
      calc_op_next      = calc_op_reg;
      calc_operand_next = calc_operand_reg;
      rsp_valid_next    = 1'b0;
      rsp_data_next     = rsp_data_reg;
      case (state_reg)
         ST_IDLE: begin
            if (pop_now) begin
               state_next        = ST_ISSUE;
               calc_stb_next     = 1'b1;
               calc_op_next      = head_cmd.op;
               calc_operand_next = head_cmd.operand;
            end
         end
         ST_ISSUE: state_next = ST_CAPTURE;
         ST_CAPTURE: begin
            // The calculator has registered the strobed operation by now.
            rsp_data_next  = calc_result;
            rsp_valid_next = 1'b1;
            if (GAP > 0) begin
               state_next    = ST_WAIT;
               wait_cnt_next = WAIT_LOAD;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (wait_cnt_reg == '0) state_next = ST_IDLE;
            else                    wait_cnt_next = wait_cnt_reg - 1'b1;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= ST_IDLE;
         wait_cnt_reg     <= '0;
         calc_stb_reg     <= 1'b0;
         calc_op_reg      <= OP_ADD;
         calc_operand_reg <= '0;
         rsp_valid_reg    <= 1'b0;
         rsp_data_reg     <= '0;
      end else begin
         state_reg        <= state_next;
         wait_cnt_reg     <= wait_cnt_next;
         calc_stb_reg     <= calc_stb_next;
         calc_op_reg      <= calc_op_next;
         calc_operand_reg <= calc_operand_next;
         rsp_valid_reg    <= rsp_valid_next;
         rsp_data_reg     <= rsp_data_next;
      end
   end

   assign calc_stb     = calc_stb_reg;
   assign calc_op      = calc_op_reg;
   assign calc_operand = calc_operand_reg;
   assign rsp_valid    = rsp_valid_reg;
   assign rsp_data     = rsp_data_reg;
   assign busy         = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_calc_cmd_issuer.sv
// Self-checking bench for calc_cmd_issuer: directed scenarios plus random
// traffic, scored against a cycle-level queue/timing reference model.
module tb_calc_cmd_issuer;
   import calc_pkg::*;

   localparam int DEPTH = 4;
   localparam int GAP   = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'b00;
   logic [7:0]    cmd_operand = 8'h00;
   logic          flush = 1'b0;
   logic          calc_stb;
   logic [1:0]    calc_op;
   logic [7:0]    calc_operand;
   logic [7:0]    calc_result;
   logic          rsp_valid;
   logic [7:0]    rsp_data;
   logic          busy;
   logic [CW-1:0] count;

   calc_cmd_issuer #(.DEPTH(DEPTH), .GAP(GAP)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_operand  (cmd_operand),
      .flush        (flush),
      .calc_stb     (calc_stb),
      .calc_op      (calc_op),
      .calc_operand (calc_operand),
      .calc_result  (calc_result),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .busy         (busy),
      .count        (count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a | b;
         default: return (a == b) ? 8'd1 : 8'd0;
      endcase
   endfunction

   // Calculator stand-in: registered accumulator updated on each strobe.
   logic [7:0] acc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)        acc <= 8'h00;
      else if (calc_stb) acc <= alu(calc_op, acc, calc_operand);
   end
   assign calc_result = acc;

   // Reference model state
   logic [9:0] m_q[$];
   int         next_pop = 0;
   int         stb_at = -1;
   int         rsp_at = -1;
   logic [9:0] stb_cmd = '0;
   logic [7:0] rsp_exp = '0;
   logic [7:0] ref_acc = '0;
   logic [1:0] last_op = '0;
   logic [7:0] last_operand = '0;
   int         last_stb = -1;
   bit         m_accepted = 1'b0;
   int         push_edge = 0;
   int         max_count = 0;

   // Observation logs for directed scenarios
   int         stb_cyc_q[$];
   logic [7:0] stb_opd_q[$];
   int         rsp_cyc_q[$];
   logic [7:0] rsp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic clear_logs();
      stb_cyc_q.delete(); stb_opd_q.delete(); rsp_cyc_q.delete(); rsp_q.delete();
   endtask

   task automatic check_outputs();
      bit exp_stb;
      exp_stb = (cyc == stb_at);
      check_val("calc_stb", 32'(calc_stb), 32'(exp_stb));
      if (exp_stb) begin
         last_op      = stb_cmd[9:8];
         last_operand = stb_cmd[7:0];
      end
      check_val("calc_op", 32'(calc_op), 32'(last_op));
      check_val("calc_operand", 32'(calc_operand), 32'(last_operand));
      if (calc_stb) begin
         if (last_stb >= 0) check_val("stb_gap_ok", 32'((cyc - last_stb - 1) >= GAP + 2), 32'd1);
         last_stb = cyc;
         stb_cyc_q.push_back(cyc);
         stb_opd_q.push_back(calc_operand);
      end
      check_val("rsp_valid", 32'(rsp_valid), 32'(cyc == rsp_at));
      if (cyc == rsp_at) check_val("rsp_data", 32'(rsp_data), 32'(rsp_exp));
      if (rsp_valid) begin
         rsp_cyc_q.push_back(cyc);
         rsp_q.push_back(rsp_data);
      end
      check_val("count", 32'(count), 32'(m_q.size()));
      if (int'(count) > max_count) max_count = int'(count);
      check_val("busy", 32'(busy), 32'((m_q.size() > 0) || (cyc < next_pop - 1)));
   endtask

   task automatic step(input bit v, input logic [1:0] op, input logic [7:0] opd, input bit fl);
      bit pop_pred;
      bit exp_ready;
      int e;
      @(negedge clk);
      check_outputs();
      cmd_valid = v; cmd_op = op; cmd_operand = opd; flush = fl;
      e = cyc + 1;
      pop_pred  = (m_q.size() > 0) && (e >= next_pop);
      exp_ready = (m_q.size() < DEPTH) || pop_pred;
      check_val("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
      m_accepted = v && exp_ready && !fl;
      if (pop_pred) begin
         stb_cmd  = m_q.pop_front();
         ref_acc  = alu(stb_cmd[9:8], ref_acc, stb_cmd[7:0]);
         rsp_exp  = ref_acc;
         stb_at   = e;
         rsp_at   = e + 2;
         next_pop = e + GAP + 3;
      end
      if (fl) m_q.delete();
      if (m_accepted) begin
         m_q.push_back({op, opd});
         push_edge = e;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 2'b00, 8'h00, 1'b0);
   endtask

   task automatic push_cmd(input logic [1:0] op, input logic [7:0] opd);
      int tries;
      tries = 0;
      do begin
         step(1'b1, op, opd, 1'b0);
         tries++;
      end while (!m_accepted && tries < 50);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; flush = 1'b0;
      #1;
      check_val("rst_calc_stb", 32'(calc_stb), 32'd0);
      check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_val("rst_count", 32'(count), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_calc_op", 32'(calc_op), 32'd0);
      check_val("rst_calc_operand", 32'(calc_operand), 32'd0);
      check_val("rst_rsp_data", 32'(rsp_data), 32'd0);
      m_q.delete();
      next_pop = 0; stb_at = -1; rsp_at = -1; last_stb = -1;
      last_op = '0; last_operand = '0; ref_acc = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("rst_cmd_ready", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   initial begin
      int rsp_before;
      #3;
      do_reset();

      // Single command latency and result
      clear_logs();
      step(1'b1, OP_ADD, 8'd5, 1'b0);
      idle(10);
      check_val("single_stb_count", 32'(stb_cyc_q.size()), 32'd1);
      check_val("single_stb_latency", 32'(stb_cyc_q[0] - push_edge), 32'd1);
      check_val("single_rsp_count", 32'(rsp_q.size()), 32'd1);
      check_val("single_rsp_latency", 32'(rsp_cyc_q[0] - push_edge), 32'd3);
      check_val("single_rsp_data", 32'(rsp_q[0]), 32'd5);

      // Back-to-back sequence from a cleared accumulator
      do_reset();
      clear_logs();
      step(1'b1, OP_ADD, 8'd10, 1'b0);
      step(1'b1, OP_SUB, 8'd3, 1'b0);
      step(1'b1, OP_OR, 8'h80, 1'b0);
      step(1'b1, OP_EQ, 8'h87, 1'b0);
      idle(30);
      check_val("seq_rsp_count", 32'(rsp_q.size()), 32'd4);
      check_val("seq_rsp0", 32'(rsp_q[0]), 32'd10);
      check_val("seq_rsp1", 32'(rsp_q[1]), 32'd7);
      check_val("seq_rsp2", 32'(rsp_q[2]), 32'd135);
      check_val("seq_rsp3", 32'(rsp_q[3]), 32'd1);

      // Full FIFO: first command goes straight to the FSM, next four fill it
      max_count = 0;
      for (int i = 0; i < 6; i++) push_cmd(OP_ADD, 8'(8'h20 + i));
      idle(40);
      check_val("full_max_count", 32'(max_count), 32'(DEPTH));

      // Flush while the first of three is in CAPTURE
      rsp_before = rsp_q.size();
      step(1'b1, OP_OR, 8'h01, 1'b0);
      step(1'b1, OP_OR, 8'h02, 1'b0);
      step(1'b1, OP_OR, 8'h04, 1'b0);
      step(1'b0, 2'b00, 8'h00, 1'b1);
      idle(10);
      check_val("flush_rsp_count", 32'(rsp_q.size() - rsp_before), 32'd1);
      check_val("flush_count", 32'(count), 32'd0);
      check_val("flush_busy", 32'(busy), 32'd0);

      // Reset while the command is in ISSUE
      clear_logs();
      step(1'b1, OP_SUB, 8'd9, 1'b0);
      step(1'b0, 2'b00, 8'h00, 1'b0);
      @(negedge clk);
      check_outputs();
      do_reset();
      idle(10);
      check_val("rstmid_rsp_count", 32'(rsp_q.size()), 32'd0);

      // Wrap-around: ten commands through the four-entry FIFO, in order
      clear_logs();
      for (int i = 1; i <= 10; i++) push_cmd(OP_ADD, 8'(i));
      idle(60);
      check_val("wrap_stb_count", 32'(stb_opd_q.size()), 32'd10);
      for (int i = 0; i < 10; i++) check_val("wrap_order", 32'(stb_opd_q[i]), 32'(i + 1));

      // Random traffic with occasional flushes
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
              ($urandom_range(0, 19) == 0));
      end
      idle(20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
